// File: rtl/lilme_host_seq.sv
// ============================================================================
// Module   : lilme_host_seq
// Purpose  : Host-side command sequencer for the LILME 4x4 matrix engine.
//            Loads matrix A/B word streams into the engine, kicks off a
//            multiply, captures the engine result stream into a local
//            circular buffer and replays it to the host on request.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset             clock (rising edge) / async active-high reset
//   cmd_valid/cmd_op       host command (0 load A, 1 load B, 2 multiply,
//                          3 read captured result); cmd_ready high in IDLE
//   wr_valid/wr_data       load-word stream; wr_ready high in LOAD
//   me_opcode, a_opcode,   engine controller / matrix control strobes
//   b_opcode, me_data      and engine data input
//   me_busy, me_rdata      engine busy flag and result data
//   rd_valid/rd_data       captured-result stream to host, rd_ready back
//   done, err              single-cycle completion / failure pulses
// ============================================================================
`default_nettype none

module lilme_host_seq #(
   parameter int DW      = 32,
   parameter int N_LOAD  = 16,
   parameter int N_OUT   = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   input  logic [1:0]    cmd_op,
   output logic          cmd_ready,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   output logic [2:0]    me_opcode,
   output logic          a_opcode,
   output logic          b_opcode,
   output logic [DW-1:0] me_data,
   input  logic          me_busy,
   input  logic [DW-1:0] me_rdata,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   input  logic          rd_ready,
   output logic          done,
   output logic          err
);

   localparam int CW = $clog2((N_LOAD > N_OUT) ? N_LOAD : N_OUT);
   localparam int PW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int NW = $clog2(N_OUT + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [2:0] c_ST_IDLE      = 3'd0;
   localparam logic [2:0] c_ST_LOAD      = 3'd1;
   localparam logic [2:0] c_ST_LOAD_WAIT = 3'd2;
   localparam logic [2:0] c_ST_ISSUE     = 3'd3;
   localparam logic [2:0] c_ST_CAPTURE   = 3'd4;
   localparam logic [2:0] c_ST_DRAIN     = 3'd5;

   localparam logic [2:0] c_OP_NOP    = 3'b000;
   localparam logic [2:0] c_OP_LOAD_A = 3'b010;
   localparam logic [2:0] c_OP_LOAD_B = 3'b011;
   localparam logic [2:0] c_OP_MUL    = 3'b101;

   logic [2:0]    r_state, w_next;
   logic          r_op_b;         // 1: current load targets matrix B
   logic [CW-1:0] r_cnt;          // load word counter / drain index k
   logic [TW-1:0] r_tmo;
   logic [PW-1:0] r_wptr, r_base;
   logic [NW-1:0] r_ncap;         // busy cycles captured, saturating at N_OUT
   logic          r_res_valid, r_seen_busy, r_done, r_err;
   logic [DW-1:0] r_buf [N_OUT];

   logic          w_accept, w_load_beat, w_load_last, w_wait_done;
   logic          w_cap_write, w_cap_done, w_timeout, w_rd_xfer;
   logic          w_drain_last, w_bad_rd;
   logic [PW:0]   w_rd_sum;
   logic [PW-1:0] w_rd_idx;

   // Read index = (base + k) mod N_OUT without requiring a power-of-two depth.
   assign w_rd_sum = {1'b0, r_base} + {1'b0, PW'(r_cnt)};
   assign w_rd_idx = (w_rd_sum >= (PW+1)'(N_OUT)) ? PW'(w_rd_sum - (PW+1)'(N_OUT))
                                                  : PW'(w_rd_sum);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= c_ST_IDLE;
      else       r_state <= w_next;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_next       = r_state;
      w_accept     = 1'b0;
      w_load_beat  = 1'b0;
      w_load_last  = 1'b0;
      w_wait_done  = 1'b0;
      w_cap_write  = 1'b0;
      w_cap_done   = 1'b0;
      w_timeout    = 1'b0;
      w_rd_xfer    = 1'b0;
      w_drain_last = 1'b0;
      w_bad_rd     = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            if (cmd_valid) begin
               w_accept = 1'b1;
               case (cmd_op)
                  2'd0, 2'd1: w_next = c_ST_LOAD;
                  2'd2:       w_next = c_ST_ISSUE;
                  default: begin
                     if (r_res_valid) w_next   = c_ST_DRAIN;
                     else             w_bad_rd = 1'b1;
                  end
               endcase
            end
         end
         c_ST_LOAD: begin
            w_load_beat = wr_valid;
            if (wr_valid && (r_cnt == CW'(N_LOAD - 1))) begin
               w_load_last = 1'b1;
               w_next      = c_ST_LOAD_WAIT;
            end
         end
         c_ST_LOAD_WAIT: begin
            if (!me_busy) begin
               w_wait_done = 1'b1;
               w_next      = c_ST_IDLE;
            end else if (r_tmo == TW'(TIMEOUT - 1)) begin
               w_timeout = 1'b1;
               w_next    = c_ST_IDLE;
            end
         end
         c_ST_ISSUE: w_next = c_ST_CAPTURE;
         c_ST_CAPTURE: begin
            w_cap_write = me_busy;
            // Busy low before the engine ever went busy is still the
            // pre-start gap, not completion.
            if (!me_busy && r_seen_busy) begin
               w_cap_done = 1'b1;
               w_next     = c_ST_IDLE;
            end else if (r_tmo == TW'(TIMEOUT - 1)) begin
               w_timeout = 1'b1;
               w_next    = c_ST_IDLE;
            end
         end
         c_ST_DRAIN: begin
            w_rd_xfer = rd_ready;
            if (rd_ready && (r_cnt == CW'(N_OUT - 1))) begin
               w_drain_last = 1'b1;
               w_next       = c_ST_IDLE;
            end
         end
         default: w_next = c_ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------- outputs
   always_comb begin
      cmd_ready = (r_state == c_ST_IDLE);
      wr_ready  = (r_state == c_ST_LOAD);
      rd_valid  = (r_state == c_ST_DRAIN);
      me_opcode = c_OP_NOP;
      a_opcode  = 1'b0;
      b_opcode  = 1'b0;
      me_data   = '0;
      rd_data   = '0;
      case (r_state)
         c_ST_LOAD: begin
            me_data = wr_data;
            if (wr_valid) begin
               me_opcode = r_op_b ? c_OP_LOAD_B : c_OP_LOAD_A;
               a_opcode  = !r_op_b;
               b_opcode  = r_op_b;
            end
         end
         c_ST_ISSUE: me_opcode = c_OP_MUL;
         c_ST_DRAIN: rd_data   = r_buf[w_rd_idx];
         default: ;
      endcase
      done = r_done;
      err  = r_err;
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op_b      <= 1'b0;
         r_cnt       <= '0;
         r_tmo       <= '0;
         r_wptr      <= '0;
         r_base      <= '0;
         r_ncap      <= '0;
         r_res_valid <= 1'b0;
         r_seen_busy <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= w_wait_done | w_cap_done | w_drain_last;
         r_err  <= w_bad_rd | w_timeout | (w_cap_done && (r_ncap != NW'(N_OUT)));

         if (w_accept) begin
            r_op_b <= cmd_op[0];
            r_cnt  <= '0;
            r_tmo  <= '0;
         end

         if (w_load_beat)
            r_cnt <= w_load_last ? '0 : r_cnt + 1'b1;

         if (r_state == c_ST_ISSUE) begin
            r_res_valid <= 1'b0;
            r_seen_busy <= 1'b0;
            r_ncap      <= '0;
            r_tmo       <= '0;
         end

         if ((r_state == c_ST_LOAD_WAIT) || (r_state == c_ST_CAPTURE))
            r_tmo <= r_tmo + 1'b1;

         if (w_cap_write) begin
            r_wptr      <= (r_wptr == PW'(N_OUT - 1)) ? '0 : r_wptr + 1'b1;
            r_seen_busy <= 1'b1;
            if (r_ncap != NW'(N_OUT))
               r_ncap <= r_ncap + 1'b1;
         end

         // After wrap-around the write pointer sits on the oldest entry.
         if (w_cap_done) begin
            r_res_valid <= 1'b1;
            r_base      <= r_wptr;
         end

         if (w_timeout)
            r_res_valid <= 1'b0;

         if (w_rd_xfer)
            r_cnt <= w_drain_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Result buffer: deliberately not reset, guarded by r_res_valid instead.
   always_ff @(posedge clk) begin
      if (w_cap_write)
         r_buf[r_wptr] <= me_rdata;
   end

endmodule

`default_nettype wire

// File: tb/tb_lilme_host_seq.sv
// ============================================================================
// Module   : tb_lilme_host_seq
// Purpose  : Self-checking bench for lilme_host_seq with a small engine model
//            and a queue-based model of the expected result read-out.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lilme_host_seq;

   localparam int DW      = 32;
   localparam int N_LOAD  = 16;
   localparam int N_OUT   = 64;
   localparam int TIMEOUT = 1024;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic [1:0]    cmd_op;
   logic          cmd_ready;
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic [2:0]    me_opcode;
   logic          a_opcode;
   logic          b_opcode;
   logic [DW-1:0] me_data;
   logic          me_busy;
   logic [DW-1:0] me_rdata;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_ready;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   lilme_host_seq #(
      .DW(DW), .N_LOAD(N_LOAD), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .me_opcode(me_opcode), .a_opcode(a_opcode), .b_opcode(b_opcode),
      .me_data(me_data), .me_busy(me_busy), .me_rdata(me_rdata),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .done(done), .err(err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Expected read-out: the last N_OUT words the engine delivered while busy.
   logic [DW-1:0] exp_rd [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // 3 units later, well away from either clock edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      #3 check("cmd_ready_at_issue", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic expect_rd_err();
      send_cmd(2'd3);
      #3;
      check("rd_err_pulse", err, 1);
      check("rd_err_no_valid", rd_valid, 0);
      check("rd_err_cmd_ready", cmd_ready, 1);
      tick();
      #3;
      check("rd_err_single", err, 0);
      check("rd_err_no_valid2", rd_valid, 0);
      tick();
   endtask

   task automatic do_load(input bit op_b, input bit det);
      logic [DW-1:0] words [N_LOAD];
      logic [DW-1:0] seen [$];
      logic [2:0]    exp_opc;
      int i = 0, act = 0, bad = 0, cyc = 0, gap = 0, nb;
      exp_opc = op_b ? 3'b011 : 3'b010;
      for (int k = 0; k < N_LOAD; k++) words[k] = det ? DW'(k + 1) : $urandom;
      send_cmd({1'b0, op_b});
      while (i < N_LOAD && cyc < 200) begin
         if (det) begin
            wr_valid = !(i == 4 && gap < 2);
            if (!wr_valid) gap++;
         end else begin
            wr_valid = ($urandom_range(0, 3) != 0);
         end
         wr_data = wr_valid ? words[i] : $urandom;
         #3;
         if (wr_valid && wr_ready) begin
            seen.push_back(me_data);
            if (me_opcode == exp_opc && a_opcode == !op_b && b_opcode == op_b) act++;
            i++;
         end else if (me_opcode != 3'b000 || a_opcode || b_opcode) begin
            bad++;
         end
         tick();
         cyc++;
      end
      wr_valid = 1'b0;
      check("load_beats", seen.size(), N_LOAD);
      check("load_active_cycles", act, N_LOAD);
      check("load_idle_opcode", bad, 0);
      for (int k = 0; k < seen.size() && k < N_LOAD; k++)
         check("load_data", seen[k], words[k]);
      // Engine is busy for a few cycles after the last word.
      me_busy = 1'b1;
      nb = $urandom_range(1, 4);
      bad = 0;
      for (int c = 0; c < nb; c++) begin
         #3;
         if (me_opcode != 3'b000 || a_opcode || b_opcode || wr_ready || done) bad++;
         tick();
      end
      check("load_wait_quiet", bad, 0);
      me_busy = 1'b0;
      #3 check("load_done_early", done, 0);
      tick();
      #3;
      check("load_done", done, 1);
      check("load_err", err, 0);
      check("load_back_idle", cmd_ready, 1);
      tick();
      #3 check("load_done_single", done, 0);
      tick();
   endtask

   task automatic do_mul(input bit det, input int calc, input int n_data);
      logic          pb [$];
      logic [DW-1:0] pd [$];
      logic [DW-1:0] cap [$];
      int pre, bad = 0;
      pre = det ? 0 : $urandom_range(0, 3);
      for (int c = 0; c < pre; c++)    begin pb.push_back(1'b0); pd.push_back($urandom); end
      for (int c = 0; c < calc; c++)   begin pb.push_back(1'b1); pd.push_back($urandom); end
      for (int c = 0; c < n_data; c++) begin
         pb.push_back(1'b1);
         pd.push_back(det ? DW'(32'h100 + c) : $urandom);
      end
      send_cmd(2'd2);
      me_busy = 1'b0;
      #3 check("issue_opcode", me_opcode, 3'b101);
      tick();
      for (int c = 0; c < pb.size(); c++) begin
         me_busy  = pb[c];
         me_rdata = pd[c];
         if (pb[c]) cap.push_back(pd[c]);
         #3;
         if (me_opcode != 3'b000 || done || err || cmd_ready) bad++;
         tick();
      end
      check("capture_quiet", bad, 0);
      me_busy  = 1'b0;
      me_rdata = $urandom;
      #3 check("cap_done_early", done, 0);
      tick();
      #3;
      check("cap_done", done, 1);
      check("cap_err", err, (cap.size() < N_OUT) ? 1 : 0);
      check("cap_back_idle", cmd_ready, 1);
      tick();
      while (cap.size() > N_OUT) void'(cap.pop_front());
      exp_rd = cap;
   endtask

   task automatic do_drain(input int mode, input int stop_at, input bit hammer);
      logic [DW-1:0] held;
      bit stalled = 0;
      int k = 0, cyc = 0, badv = 0;
      held = '0;
      send_cmd(2'd3);
      while (k < N_OUT && cyc < 1000) begin
         if (stop_at >= 0 && k == stop_at) break;
         case (mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = (cyc % 2 == 0);
            default: rd_ready = 1'($urandom_range(0, 1));
         endcase
         cmd_valid = hammer && (k < N_OUT - 1);
         cmd_op    = 2'($urandom_range(0, 3));
         #3;
         if (!rd_valid) badv++;
         if (stalled) check("rd_stable", rd_data, held);
         if (rd_ready) begin
            check("rd_data", rd_data, exp_rd[k]);
            k++;
            stalled = 0;
         end else begin
            stalled = 1;
            held    = rd_data;
         end
         tick();
         cyc++;
      end
      cmd_valid = 1'b0;
      check("drain_valid_held", badv, 0);
      if (stop_at < 0) begin
         rd_ready = 1'b0;
         check("drain_count", k, N_OUT);
         #3;
         check("drain_done", done, 1);
         check("drain_valid_off", rd_valid, 0);
         check("drain_back_idle", cmd_ready, 1);
         tick();
      end
   endtask

   task automatic do_timeout();
      int cnt = 0;
      bit got = 0;
      send_cmd(2'd2);
      #3 check("tmo_issue_opcode", me_opcode, 3'b101);
      tick();
      me_busy = 1'b1;
      while (cnt < TIMEOUT + 20) begin
         #3;
         cnt++;
         if (err) begin got = 1; break; end
         tick();
      end
      check("tmo_err_seen", got, 1);
      check("tmo_latency_ok", (cnt >= TIMEOUT && cnt <= TIMEOUT + 2) ? 1 : 0, 1);
      check("tmo_no_done", done, 0);
      check("tmo_back_idle", cmd_ready, 1);
      check("tmo_opcode_idle", me_opcode, 3'b000);
      me_busy = 1'b0;
      exp_rd.delete();
      tick();
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      me_busy   = 1'b0;
      me_rdata  = '0;
      rd_ready  = 1'b0;
      tick();
      tick();
      #3;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_done_err", {done, err}, 2'b00);
      check("rst_ab_opcode", {a_opcode, b_opcode}, 2'b00);
      check("rst_me_opcode", me_opcode, 3'b000);
      check("rst_me_data", me_data, 0);
      check("rst_rd_data", rd_data, 0);
      tick();
      reset = 1'b0;
      tick();

      // Read before any capture is refused.
      expect_rd_err();

      // Loads: deterministic A with a gap at word 5, then random B.
      do_load(1'b0, 1'b1);
      do_load(1'b1, 1'b0);

      // Multiply with 3 CALC cycles then 64 data words, full-rate read,
      // then a re-read with rd_ready toggling.
      do_mul(1'b1, 3, N_OUT);
      do_drain(0, -1, 1'b0);
      do_drain(1, -1, 1'b0);

      // Random multiply, random back-pressure, commands hammered mid-read.
      do_mul(1'b0, $urandom_range(0, 6), N_OUT);
      do_drain(2, -1, 1'b1);

      // Short capture completes with err, then timeout clears the result.
      do_mul(1'b0, 0, 10);
      do_timeout();
      expect_rd_err();

      // Reset mid-read at word 10.
      do_mul(1'b1, 3, N_OUT);
      do_drain(0, 10, 1'b0);
      reset = 1'b1;
      #1;
      check("rst_mid_rd_valid", rd_valid, 0);
      check("rst_mid_cmd_ready", cmd_ready, 1);
      tick();
      reset = 1'b0;
      rd_ready = 1'b0;
      exp_rd.delete();
      tick();
      expect_rd_err();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
